tri_bus_turnaround: RTL and testbench

Parametrised bidirectional pad-bus controller: WIDTH tristate pads with registered output data and registered output enable. Direction changes go through a turnaround interval in which every pad is high-Z, so the chip and the far end never drive the bus at the same time. Inbound data passes through a synchroniser. Sits between core logic and the top-level inout pins; it generalises the single registered-OE tristate IO cell to a multi-bit bus with handshakes.

---
 rtl/tri_bus_turnaround.sv | 156 +++++++++++++++
 tb/tb_tri_bus_turnaround.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_bus_turnaround.sv
// tri_bus_turnaround
// Multi-bit bidirectional pad-bus controller. Outbound data and the output
// enable are both registered, and every change of direction passes through a
// turnaround window in which all pads float, so the chip and the far end never
// drive the bus at the same time. Inbound pad values pass through a
// SYNC_STAGES-deep synchroniser before reaching the core.
//
// Parameters:
//   WIDTH        number of pads / data width
//   TURN_CYCLES  high-Z cycles on each direction change (1..15)
//   SYNC_STAGES  depth of the inbound synchroniser (1..4)
//
// Ports:
//   clk       clock, all state on the rising edge
//   resetn    asynchronous active-low reset
//   dir_req   1 = chip wants to drive the bus, 0 = chip receives
//   tx_valid  tx_data holds a word to send
//   tx_ready  word on tx_data is taken this cycle
//   tx_data   outbound word
//   rx_valid  rx_data holds a valid synchronised sample
//   rx_data   synchronised inbound word
//   driving   registered output enable, mirrors the pad enable
//   pad       bus pins, driven from the output register only while driving=1
//
// Optional feature (compile-time macro TRI_BUS_TURN_ABORT_EN):
//   When defined, a turnaround toward TX is abandoned as soon as dir_req drops
//   (straight back to RX), and a turnaround toward RX is restarted toward TX
//   when dir_req rises. Pads stay high-Z on both paths. When undefined, every
//   turnaround runs to completion before dir_req is looked at again.

module tri_bus_turnaround #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             dir_req,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             driving,
  inout  wire  [WIDTH-1:0] pad
);

  typedef enum logic [1:0] {
    ST_RX,
    ST_TURN_TX,
    ST_TX,
    ST_TURN_RX
  } state_e;

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);
  localparam logic [2:0] FILL_FULL = 3'(SYNC_STAGES);

  state_e           state_q, state_d;
  logic [3:0]       turnCnt_q, turnCnt_d;
  logic [2:0]       fillCnt_q, fillCnt_d;
  logic             driving_q, driving_d;
  logic             rxValid_q, rxValid_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [WIDTH-1:0] syncChain_q [SYNC_STAGES];

  // tx_ready is the only output with a combinational term: it must fall in the
  // very cycle dir_req drops so no word is taken on the way out of TX.
  assign tx_ready = driving_q & dir_req;
  assign driving  = driving_q;
  assign rx_valid = rxValid_q;
  assign rx_data  = syncChain_q[SYNC_STAGES-1];

  // The pad enable is a flop, so reset floats the bus without waiting for a clock.
  assign pad = driving_q ? outData_q : {WIDTH{1'bz}};

  // Next-state logic. Turnaround counters count down to zero and then move on;
  // the abort overrides sit after the normal decision so they win when enabled.
  always_comb begin
    state_d   = state_q;
    turnCnt_d = turnCnt_q;
    unique case (state_q)
      ST_RX: begin
        if (dir_req) begin
          state_d   = ST_TURN_TX;
          turnCnt_d = TURN_LOAD;
        end
      end
      ST_TURN_TX: begin
        if (turnCnt_q == 4'd0) state_d = ST_TX;
        else                   turnCnt_d = turnCnt_q - 4'd1;
`ifdef TRI_BUS_TURN_ABORT_EN
        if (!dir_req) begin
          state_d   = ST_RX;
          turnCnt_d = 4'd0;
        end
`endif
      end
      ST_TX: begin
        if (!dir_req) begin
          state_d   = ST_TURN_RX;
          turnCnt_d = TURN_LOAD;
        end
      end
      ST_TURN_RX: begin
        if (turnCnt_q == 4'd0) state_d = ST_RX;
        else                   turnCnt_d = turnCnt_q - 4'd1;
`ifdef TRI_BUS_TURN_ABORT_EN
        if (dir_req) begin
          state_d   = ST_TURN_TX;
          turnCnt_d = TURN_LOAD;
        end
`endif
      end
      default: begin
        state_d   = ST_RX;
        turnCnt_d = 4'd0;
      end
    endcase
  end

  // Registered outputs and datapath. The fill count is zero in the first RX
  // cycle of every visit, so rx_valid rises exactly SYNC_STAGES cycles later,
  // once the chain holds a sample taken while the far end owned the bus.
  always_comb begin
    if (state_d != ST_RX || state_q != ST_RX) fillCnt_d = 3'd0;
    else if (fillCnt_q != FILL_FULL)          fillCnt_d = fillCnt_q + 3'd1;
    else                                      fillCnt_d = fillCnt_q;
    rxValid_d = (state_d == ST_RX) && (fillCnt_d == FILL_FULL);
    driving_d = (state_d == ST_TX);
    outData_d = (tx_valid && tx_ready) ? tx_data : outData_q;
  end

  // Single state register for the FSM, its registered outputs and the
  // synchroniser chain, which shifts every cycle and is only cleared by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_RX;
      turnCnt_q <= 4'd0;
      fillCnt_q <= 3'd0;
      driving_q <= 1'b0;
      rxValid_q <= 1'b0;
      outData_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) syncChain_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      turnCnt_q <= turnCnt_d;
      fillCnt_q <= fillCnt_d;
      driving_q <= driving_d;
      rxValid_q <= rxValid_d;
      outData_q <= outData_d;
      syncChain_q[0] <= pad;
      for (int i = 1; i < SYNC_STAGES; i++) syncChain_q[i] <= syncChain_q[i-1];
    end
  end

endmodule

// File: tb/tb_tri_bus_turnaround.sv
// tb_tri_bus_turnaround
// Directed bench for tri_bus_turnaround (WIDTH=8, TURN_CYCLES=2, SYNC_STAGES=2).
// The stimulus thread queues hand-computed expectations tagged with the cycle
// they apply to; a monitor on the falling edge pops and checks every entry due
// in the current cycle. Cycle k is the interval following the k-th rising edge.

module tb_tri_bus_turnaround;

  localparam int K_DRV  = 0;
  localparam int K_RDY  = 1;
  localparam int K_RV   = 2;
  localparam int K_DATA = 3;
  localparam int K_RAW  = 4;
  localparam int K_PAD  = 5;

  typedef struct {
    int          cyc;
    int          kind;
    logic [7:0]  val;
    logic [95:0] tag;
  } expEntry_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       dirReq;
  logic       txValid;
  logic       txReady;
  logic [7:0] txData;
  logic       rxValid;
  logic [7:0] rxData;
  logic       driving;
  wire  [7:0] pad;
  logic       farEn;
  logic [7:0] farData;

  int        cyc = 0;
  int        numCompared = 0;
  int        numMismatched = 0;
  expEntry_t sb[$];

  // The far end of the bus: drives only when the bench enables it.
  assign pad = farEn ? farData : 8'hzz;

  tri_bus_turnaround #(
    .WIDTH(8),
    .TURN_CYCLES(2),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .dir_req(dirReq),
    .tx_valid(txValid),
    .tx_ready(txReady),
    .tx_data(txData),
    .rx_valid(rxValid),
    .rx_data(rxData),
    .driving(driving),
    .pad(pad)
  );

  always #5 clk = ~clk;

  // Cycle stamp used by both stimulus and monitor.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) nextCycle();
  endtask

  // Queue stays sorted by cycle so expectations can be added in any order.
  task automatic pushExp(input int c, input int k, input logic [7:0] v, input logic [95:0] t);
    expEntry_t e;
    int idx;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    e.tag  = t;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].cyc > c) idx--;
    sb.insert(idx, e);
  endtask

  task automatic applyStimulus(input logic dr, input logic tv, input logic [7:0] td);
    dirReq  = dr;
    txValid = tv;
    txData  = td;
  endtask

  task automatic checkOutput(input expEntry_t e);
    logic       ok;
    logic [7:0] act;
    ok  = 1'b0;
    act = 8'h00;
    case (e.kind)
      K_DRV:  begin act = {7'd0, driving}; ok = (driving === e.val[0]); end
      K_RDY:  begin act = {7'd0, txReady}; ok = (txReady === e.val[0]); end
      K_RV:   begin act = {7'd0, rxValid}; ok = (rxValid === e.val[0]); end
      K_DATA: begin act = rxData; ok = (rxValid === 1'b1) && (rxData === e.val); end
      K_RAW:  begin act = rxData; ok = (rxData === e.val); end
      K_PAD:  begin act = pad; ok = (driving === 1'b1) && (pad === e.val); end
      default: ok = 1'b0;
    endcase
    numCompared++;
    if (!ok) begin
      numMismatched++;
      $display("[TB] FAIL %s cycle %0d: got %h (rx_valid=%b driving=%b) want %h",
               e.tag, e.cyc, act, rxValid, driving, e.val);
    end
  endtask

  // Monitor: checks everything due in the current cycle, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      expEntry_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        numCompared++;
        numMismatched++;
        $display("[TB] FAIL %s stale entry for cycle %0d seen at %0d: got none want %h",
                 e.tag, e.cyc, cyc, e.val);
      end else begin
        checkOutput(e);
      end
    end
  end

  initial begin
    int c, r, a, n, p, q;
    resetn  = 1'b0;
    farEn   = 1'b1;
    farData = 8'h00;
    applyStimulus(1'b1, 1'b1, 8'hFF);

    // Reset held with dir_req and tx_valid high: everything idle.
    nextCycle();
    nextCycle();
    c = cyc;
    pushExp(c, K_DRV, 8'd0, "rstDrv");
    pushExp(c, K_RDY, 8'd0, "rstRdy");
    pushExp(c, K_RV,  8'd0, "rstRv");
    pushExp(c, K_RAW, 8'h00, "rstData");

    // Release: rx_valid after SYNC_STAGES cycles.
    nextCycle();
    r = cyc;
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    pushExp(r,   K_RV,   8'd0,  "fillRv0");
    pushExp(r+1, K_RV,   8'd0,  "fillRv1");
    pushExp(r+2, K_DATA, 8'h00, "fillData");

    // Receive A5 then 3C, each visible two cycles later.
    a = r + 3;
    pushExp(a+2, K_DATA, 8'hA5, "rxA5");
    pushExp(a+3, K_DATA, 8'h3C, "rx3C");
    pushExp(a+4, K_DATA, 8'h00, "rx00");
    waitUntil(a);   farData = 8'hA5;
    nextCycle();    farData = 8'h3C;
    nextCycle();    farData = 8'h00;

    // RX -> TX turnaround, first word, back-to-back, gap, release.
    n = a + 6;
    pushExp(n,    K_RV,  8'd1,  "preTurnRv");
    pushExp(n+1,  K_DRV, 8'd0,  "turnTxDrv1");
    pushExp(n+1,  K_RV,  8'd0,  "turnTxRv");
    pushExp(n+1,  K_RDY, 8'd0,  "turnTxRdy");
    pushExp(n+2,  K_DRV, 8'd0,  "turnTxDrv2");
    pushExp(n+3,  K_RDY, 8'd1,  "txRdy");
    pushExp(n+4,  K_PAD, 8'h5A, "pad5A");
    pushExp(n+5,  K_PAD, 8'h01, "pad01");
    pushExp(n+6,  K_PAD, 8'h02, "pad02");
    pushExp(n+7,  K_PAD, 8'h03, "pad03");
    pushExp(n+8,  K_RDY, 8'd1,  "gapRdy");
    pushExp(n+8,  K_PAD, 8'h03, "gapHold1");
    pushExp(n+9,  K_PAD, 8'h03, "gapHold2");
    pushExp(n+9,  K_RDY, 8'd0,  "leaveRdy");
    pushExp(n+10, K_DRV, 8'd0,  "turnRxDrv1");
    pushExp(n+11, K_DRV, 8'd0,  "turnRxDrv2");
    pushExp(n+12, K_DRV, 8'd0,  "backRxDrv");
    pushExp(n+13, K_RV,  8'd0,  "refillRv");
    pushExp(n+14, K_DATA, 8'hC3, "refillC3");
    waitUntil(n);
    farEn = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    waitUntil(n+3); applyStimulus(1'b1, 1'b1, 8'h5A);
    waitUntil(n+4); applyStimulus(1'b1, 1'b1, 8'h01);
    waitUntil(n+5); applyStimulus(1'b1, 1'b1, 8'h02);
    waitUntil(n+6); applyStimulus(1'b1, 1'b1, 8'h03);
    waitUntil(n+7); applyStimulus(1'b1, 1'b0, 8'hEE);
    waitUntil(n+9); applyStimulus(1'b0, 1'b1, 8'h77);
    waitUntil(n+10); applyStimulus(1'b0, 1'b0, 8'h00);
    waitUntil(n+12); farEn = 1'b1; farData = 8'hC3;

    // One-cycle dir_req pulse in RX.
    p = n + 16;
    pushExp(p,   K_RV,  8'd1, "pulsePreRv");
    pushExp(p+1, K_DRV, 8'd0, "pulseDrv1");
    pushExp(p+1, K_RV,  8'd0, "pulseRv1");
`ifdef TRI_BUS_TURN_ABORT_EN
    pushExp(p+2, K_DRV, 8'd0, "abortDrv2");
    pushExp(p+3, K_DRV, 8'd0, "abortDrv3");
    pushExp(p+3, K_RV,  8'd0, "abortRv3");
    pushExp(p+4, K_DRV, 8'd0, "abortDrv4");
    pushExp(p+4, K_DATA, 8'h96, "abortData");
    pushExp(p+5, K_DRV, 8'd0, "abortDrv5");
`else
    pushExp(p+2, K_DRV, 8'd0, "pulseDrv2");
    pushExp(p+3, K_DRV, 8'd1, "pulseTxDrv");
    pushExp(p+3, K_RDY, 8'd0, "pulseTxRdy");
    pushExp(p+3, K_PAD, 8'h03, "pulseTxPad");
    pushExp(p+4, K_DRV, 8'd0, "pulseDrv4");
    pushExp(p+5, K_DRV, 8'd0, "pulseDrv5");
    pushExp(p+5, K_RV,  8'd0, "pulseRv5");
    pushExp(p+7, K_RV,  8'd0, "pulseRv7");
    pushExp(p+8, K_DATA, 8'h96, "pulseData");
`endif
    waitUntil(p);
    farEn = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    waitUntil(p+1); applyStimulus(1'b0, 1'b0, 8'h00);
`ifdef TRI_BUS_TURN_ABORT_EN
    waitUntil(p+2);
`else
    waitUntil(p+6);
`endif
    farEn = 1'b1;
    farData = 8'h96;

    // Asynchronous reset while driving FF.
    q = p + 12;
    pushExp(q+4, K_PAD, 8'hFF, "padFF");
    pushExp(q+5, K_DRV, 8'd0,  "asyncDrv");
    pushExp(q+5, K_RDY, 8'd0,  "asyncRdy");
    pushExp(q+5, K_RV,  8'd0,  "asyncRv");
    pushExp(q+5, K_RAW, 8'h00, "asyncData");
    pushExp(q+6, K_DRV, 8'd0,  "heldDrv");
    pushExp(q+8, K_RV,  8'd0,  "reRelRv");
    pushExp(q+9, K_DATA, 8'h42, "reRelData");
    waitUntil(q);
    farEn = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    waitUntil(q+3); applyStimulus(1'b1, 1'b1, 8'hFF);
    waitUntil(q+4); applyStimulus(1'b1, 1'b0, 8'hFF);
    waitUntil(q+5);
    #1 resetn = 1'b0;
    waitUntil(q+7);
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    farEn = 1'b1;
    farData = 8'h42;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) nextCycle();
    if (sb.size() > 0) begin
      $display("[TB] FAIL drain: got %0d pending entries want 0", sb.size());
      numCompared   += sb.size();
      numMismatched += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
